// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the decode pipeline register layout.
// Used by y86_regfile and decode_stage.
package y86_pkg;

    localparam int WORD_W = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef struct packed {
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        ra;
        logic [3:0]        rb;
        logic [WORD_W-1:0] valc;
        logic [WORD_W-1:0] valp;
        logic              valid;
    } d_reg_t;

    function automatic d_reg_t d_bubble();
        d_reg_t b;
        b.icode = I_NOP;
        b.ifun  = 4'h0;
        b.ra    = RNONE;
        b.rb    = RNONE;
        b.valc  = '0;
        b.valp  = '0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15-entry 64-bit register file: two combinational reads, two write ports (M wins on collision).
// Optional same-cycle write forwarding to the read ports when DECODE_BYPASS_EN is defined.
module y86_regfile
    import y86_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        src_a,
    input  logic [3:0]        src_b,
    output logic [WORD_W-1:0] val_a,
    output logic [WORD_W-1:0] val_b,
    input  logic [3:0]        dst_e,
    input  logic [WORD_W-1:0] val_e,
    input  logic [3:0]        dst_m,
    input  logic [WORD_W-1:0] val_m
);

    logic [WORD_W-1:0] regs_q [0:14];
    logic [WORD_W-1:0] regs_d [0:14];

    // E is applied first so an M write to the same register overrides it.
    always_comb begin
        regs_d = regs_q;
        if (dst_e != RNONE) regs_d[dst_e] = val_e;
        if (dst_m != RNONE) regs_d[dst_m] = val_m;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    function automatic logic [WORD_W-1:0] read_port(input logic [3:0] src);
        logic [WORD_W-1:0] v;
        if (src == RNONE) v = '0;
        else              v = regs_q[src];
`ifdef DECODE_BYPASS_EN
        if (src != RNONE) begin
            if (src == dst_m)      v = val_m;
            else if (src == dst_e) v = val_e;
        end
`endif
        return v;
    endfunction

    always_comb begin
        val_a = read_port(src_a);
        val_b = read_port(src_b);
    end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register (stall/bubble) plus source/destination decode.
// Define DECODE_BYPASS_EN to forward same-cycle write-back values to the operand reads.
module decode_stage
    import y86_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [3:0]        f_rA,
    input  logic [3:0]        f_rB,
    input  logic [63:0]       f_valC,
    input  logic [63:0]       f_valP,
    input  logic              f_valid,
    input  logic              stall,
    input  logic              bubble,
    input  logic [3:0]        w_dstE,
    input  logic [63:0]       w_valE,
    input  logic [3:0]        w_dstM,
    input  logic [63:0]       w_valM,
    output logic [3:0]        d_icode,
    output logic [3:0]        d_ifun,
    output logic [63:0]       d_valC,
    output logic [63:0]       d_valP,
    output logic              d_valid,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3:0]        d_dstE,
    output logic [3:0]        d_dstM,
    output logic [63:0]       d_valA,
    output logic [63:0]       d_valB
);

    d_reg_t d_q, d_d;

    // Bubble has priority over stall.
    always_comb begin
        d_d = d_q;
        if (bubble) begin
            d_d = d_bubble();
        end else if (!stall) begin
            d_d.icode = f_icode;
            d_d.ifun  = f_ifun;
            d_d.ra    = f_rA;
            d_d.rb    = f_rB;
            d_d.valc  = f_valC;
            d_d.valp  = f_valP;
            d_d.valid = f_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= d_bubble();
        else     d_q <= d_d;
    end

    logic [3:0]        src_a, src_b, dst_e, dst_m;
    logic [WORD_W-1:0] rf_val_a, rf_val_b;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (d_q.icode)
            I_RRMOVQ: begin src_a = d_q.ra; dst_e = d_q.rb; end
            I_IRMOVQ: begin dst_e = d_q.rb; end
            I_RMMOVQ: begin src_a = d_q.ra; src_b = d_q.rb; end
            I_MRMOVQ: begin src_b = d_q.rb; dst_m = d_q.ra; end
            I_OPQ:    begin src_a = d_q.ra; src_b = d_q.rb; dst_e = d_q.rb; end
            I_CALL:   begin src_b = RRSP; dst_e = RRSP; end
            I_RET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
            I_PUSHQ:  begin src_a = d_q.ra; src_b = RRSP; dst_e = RRSP; end
            I_POPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = d_q.ra; end
            default:  ;
        endcase
        if (!d_q.valid) begin
            src_a = RNONE;
            src_b = RNONE;
            dst_e = RNONE;
            dst_m = RNONE;
        end
    end

    y86_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .src_a (src_a),
        .src_b (src_b),
        .val_a (rf_val_a),
        .val_b (rf_val_b),
        .dst_e (w_dstE),
        .val_e (w_valE),
        .dst_m (w_dstM),
        .val_m (w_valM)
    );

    always_comb begin
        d_icode = d_q.icode;
        d_ifun  = d_q.ifun;
        d_valC  = d_q.valc;
        d_valP  = d_q.valp;
        d_valid = d_q.valid;
        d_srcA  = src_a;
        d_srcB  = src_b;
        d_dstE  = dst_e;
        d_dstM  = dst_m;
        // Call and jump carry the return/fall-through address down the valA lane.
        if (!d_q.valid)                                   d_valA = '0;
        else if (d_q.icode == I_CALL || d_q.icode == I_JXX) d_valA = d_q.valp;
        else                                              d_valA = rf_val_a;
        d_valB = d_q.valid ? rf_val_b : '0;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one task per scenario, inline checks, single summary line.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic        f_valid;
    logic        stall, bubble;
    logic [3:0]  w_dstE, w_dstM;
    logic [63:0] w_valE, w_valM;
    logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
    logic [63:0] d_valC, d_valP, d_valA, d_valB;
    logic        d_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_valid(f_valid),
        .stall(stall), .bubble(bubble),
        .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
        .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC), .d_valP(d_valP),
        .d_valid(d_valid), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .d_valA(d_valA), .d_valB(d_valB)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic drive_fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [63:0] vc, input logic [63:0] vp, input logic v);
        f_icode = ic; f_ifun = 4'h0; f_rA = ra; f_rB = rb;
        f_valC = vc; f_valP = vp; f_valid = v;
    endtask

    task automatic drive_wb(input logic [3:0] de, input logic [63:0] ve,
                            input logic [3:0] dm, input logic [63:0] vm);
        w_dstE = de; w_valE = ve; w_dstM = dm; w_valM = vm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        drive_fetch(4'h6, 4'h3, 4'h5, 64'h0, 64'h0, 1'b1);
        drive_wb(4'h3, 64'hDEAD, 4'hF, 64'h0);
        step(); step();
        tests_run++; if (d_icode !== 4'h1) begin tests_failed++; $display("FAIL reset_icode: got %h expected 1", d_icode); end
        tests_run++; if (d_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", d_valid); end
        tests_run++; if ({d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_ids: got %h expected ffff", {d_srcA, d_srcB, d_dstE, d_dstM}); end
        tests_run++; if (d_valA !== 64'h0) begin tests_failed++; $display("FAIL reset_valA: got %h expected 0", d_valA); end
        @(negedge clk);
        rst = 1'b0;
        drive_wb(4'hF, 64'h0, 4'hF, 64'h0);
        drive_fetch(4'h2, 4'h3, 4'h7, 64'h0, 64'h0, 1'b1);
        step();
        tests_run++; if (d_srcA !== 4'h3) begin tests_failed++; $display("FAIL reset_read_srcA: got %h expected 3", d_srcA); end
        tests_run++; if (d_valA !== 64'h0) begin tests_failed++; $display("FAIL reset_read_reg3: got %h expected 0", d_valA); end
        tests_run++; if (d_dstE !== 4'h7) begin tests_failed++; $display("FAIL reset_rrmovq_dstE: got %h expected 7", d_dstE); end
        tests_run++; if (d_srcB !== 4'hF) begin tests_failed++; $display("FAIL reset_rrmovq_srcB: got %h expected f", d_srcB); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drive_wb(4'h3, 64'hAA, 4'hF, 64'h0);
        drive_fetch(4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1);
        step();
        @(negedge clk);
        drive_wb(4'hF, 64'h0, 4'hF, 64'h0);
        drive_fetch(4'h6, 4'h3, 4'h5, 64'h0, 64'h0, 1'b1);
        step();
        tests_run++; if (d_srcA !== 4'h3) begin tests_failed++; $display("FAIL opq_srcA: got %h expected 3", d_srcA); end
        tests_run++; if (d_valA !== 64'hAA) begin tests_failed++; $display("FAIL opq_valA: got %h expected aa", d_valA); end
        tests_run++; if (d_srcB !== 4'h5) begin tests_failed++; $display("FAIL opq_srcB: got %h expected 5", d_srcB); end
        tests_run++; if (d_valB !== 64'h0) begin tests_failed++; $display("FAIL opq_valB: got %h expected 0", d_valB); end
        tests_run++; if (d_dstE !== 4'h5) begin tests_failed++; $display("FAIL opq_dstE: got %h expected 5", d_dstE); end
        tests_run++; if (d_dstM !== 4'hF) begin tests_failed++; $display("FAIL opq_dstM: got %h expected f", d_dstM); end
    endtask

    task automatic test_popq_collision();
        @(negedge clk);
        drive_wb(4'h4, 64'h10, 4'h4, 64'h20);
        drive_fetch(4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1);
        step();
        @(negedge clk);
        drive_wb(4'hF, 64'h0, 4'hF, 64'h0);
        drive_fetch(4'hB, 4'h6, 4'hF, 64'h0, 64'h0, 1'b1);
        step();
        tests_run++; if (d_srcA !== 4'h4) begin tests_failed++; $display("FAIL popq_srcA: got %h expected 4", d_srcA); end
        tests_run++; if (d_valA !== 64'h20) begin tests_failed++; $display("FAIL popq_valA_m_wins: got %h expected 20", d_valA); end
        tests_run++; if (d_valB !== 64'h20) begin tests_failed++; $display("FAIL popq_valB: got %h expected 20", d_valB); end
        tests_run++; if (d_dstE !== 4'h4) begin tests_failed++; $display("FAIL popq_dstE: got %h expected 4", d_dstE); end
        tests_run++; if (d_dstM !== 4'h6) begin tests_failed++; $display("FAIL popq_dstM: got %h expected 6", d_dstM); end
    endtask

    task automatic test_call_jxx();
        @(negedge clk);
        drive_fetch(4'h8, 4'hF, 4'hF, 64'h200, 64'h109, 1'b1);
        step();
        tests_run++; if (d_valA !== 64'h109) begin tests_failed++; $display("FAIL call_valA: got %h expected 109", d_valA); end
        tests_run++; if (d_srcB !== 4'h4) begin tests_failed++; $display("FAIL call_srcB: got %h expected 4", d_srcB); end
        tests_run++; if (d_valB !== 64'h20) begin tests_failed++; $display("FAIL call_valB: got %h expected 20", d_valB); end
        tests_run++; if (d_dstE !== 4'h4) begin tests_failed++; $display("FAIL call_dstE: got %h expected 4", d_dstE); end
        tests_run++; if (d_srcA !== 4'hF) begin tests_failed++; $display("FAIL call_srcA: got %h expected f", d_srcA); end
        tests_run++; if (d_valC !== 64'h200) begin tests_failed++; $display("FAIL call_valC: got %h expected 200", d_valC); end
        @(negedge clk);
        drive_fetch(4'h7, 4'hF, 4'hF, 64'h300, 64'h3F, 1'b1);
        step();
        tests_run++; if (d_valA !== 64'h3F) begin tests_failed++; $display("FAIL jxx_valA: got %h expected 3f", d_valA); end
        tests_run++; if ({d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hFFFF) begin tests_failed++; $display("FAIL jxx_ids: got %h expected ffff", {d_srcA, d_srcB, d_dstE, d_dstM}); end
    endtask

    task automatic test_full_width();
        @(negedge clk);
        drive_fetch(4'h3, 4'hF, 4'h9, 64'hFEDC_BA98_7654_3210, 64'h0, 1'b1);
        step();
        tests_run++; if (d_dstE !== 4'h9) begin tests_failed++; $display("FAIL irmovq_dstE: got %h expected 9", d_dstE); end
        tests_run++; if (d_valC !== 64'hFEDC_BA98_7654_3210) begin tests_failed++; $display("FAIL irmovq_valC: got %h expected fedcba9876543210", d_valC); end
        @(negedge clk);
        drive_wb(4'h9, 64'hFEDC_BA98_7654_3210, 4'hF, 64'h0);
        step();
        @(negedge clk);
        drive_wb(4'hF, 64'h0, 4'hF, 64'h0);
        drive_fetch(4'h4, 4'h9, 4'h3, 64'h8, 64'h0, 1'b1);
        step();
        tests_run++; if (d_valA !== 64'hFEDC_BA98_7654_3210) begin tests_failed++; $display("FAIL rmmovq_valA_64b: got %h expected fedcba9876543210", d_valA); end
        tests_run++; if (d_valB !== 64'hAA) begin tests_failed++; $display("FAIL rmmovq_valB: got %h expected aa", d_valB); end
        tests_run++; if (d_dstE !== 4'hF) begin tests_failed++; $display("FAIL rmmovq_dstE: got %h expected f", d_dstE); end
    endtask

    task automatic test_mrmovq_invalid();
        @(negedge clk);
        drive_fetch(4'h5, 4'hE, 4'h3, 64'h0, 64'h0, 1'b1);
        step();
        chk4("mrmovq_srcB", d_srcB, 4'h3);
        chk4("mrmovq_dstM", d_dstM, 4'hE);
        chk4("mrmovq_srcA", d_srcA, 4'hF);
        @(negedge clk);
        drive_fetch(4'hC, 4'h3, 4'h4, 64'h0, 64'h0, 1'b1);
        step();
        chk4("invalid_icode", d_icode, 4'hC);
        tests_run++; if ({d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hFFFF) begin tests_failed++; $display("FAIL invalid_ids: got %h expected ffff", {d_srcA, d_srcB, d_dstE, d_dstM}); end
        @(negedge clk);
        drive_fetch(4'h6, 4'h3, 4'h4, 64'h0, 64'h0, 1'b0);
        step();
        tests_run++; if ({d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hFFFF) begin tests_failed++; $display("FAIL notvalid_ids: got %h expected ffff", {d_srcA, d_srcB, d_dstE, d_dstM}); end
        tests_run++; if ({d_valA, d_valB} !== 128'h0) begin tests_failed++; $display("FAIL notvalid_vals: got %h/%h expected 0/0", d_valA, d_valB); end
    endtask

    task automatic test_stall_bubble();
        @(negedge clk);
        drive_fetch(4'hA, 4'h3, 4'hF, 64'h0, 64'h55, 1'b1);
        step();
        @(negedge clk);
        stall = 1'b1;
        drive_fetch(4'h6, 4'h1, 4'h2, 64'h77, 64'h66, 1'b1);
        step();
        @(negedge clk);
        drive_fetch(4'h2, 4'h5, 4'h6, 64'h88, 64'h99, 1'b0);
        step();
        chk4("stall_icode", d_icode, 4'hA);
        chk4("stall_srcA", d_srcA, 4'h3);
        chk4("stall_srcB", d_srcB, 4'h4);
        chk4("stall_dstE", d_dstE, 4'h4);
        tests_run++; if (d_valA !== 64'hAA) begin tests_failed++; $display("FAIL stall_valA: got %h expected aa", d_valA); end
        tests_run++; if (d_valP !== 64'h55) begin tests_failed++; $display("FAIL stall_valP: got %h expected 55", d_valP); end
        @(negedge clk);
        bubble = 1'b1;
        step();
        chk4("bubble_icode", d_icode, 4'h1);
        tests_run++; if (d_valid !== 1'b0) begin tests_failed++; $display("FAIL bubble_valid: got %b expected 0", d_valid); end
        chk4("bubble_srcA", d_srcA, 4'hF);
        tests_run++; if (d_valP !== 64'h0) begin tests_failed++; $display("FAIL bubble_valP: got %h expected 0", d_valP); end
        @(negedge clk);
        stall = 1'b0; bubble = 1'b0;
    endtask

    task automatic test_same_cycle_write();
        logic [63:0] exp_v;
        @(negedge clk);
        drive_wb(4'h2, 64'h11, 4'hF, 64'h0);
        step();
        @(negedge clk);
        drive_wb(4'hF, 64'h0, 4'hF, 64'h0);
        drive_fetch(4'h2, 4'h2, 4'h8, 64'h0, 64'h0, 1'b1);
        step();
        tests_run++; if (d_valA !== 64'h11) begin tests_failed++; $display("FAIL rrmovq_old: got %h expected 11", d_valA); end
        @(negedge clk);
        stall = 1'b1;
        drive_wb(4'hF, 64'h0, 4'h2, 64'h55);
        #1;
`ifdef DECODE_BYPASS_EN
        exp_v = 64'h55;
`else
        exp_v = 64'h11;
`endif
        tests_run++; if (d_valA !== exp_v) begin tests_failed++; $display("FAIL same_cycle_m: got %h expected %h", d_valA, exp_v); end
        step();
        tests_run++; if (d_valA !== 64'h55) begin tests_failed++; $display("FAIL next_cycle_m: got %h expected 55", d_valA); end
        @(negedge clk);
        drive_wb(4'h2, 64'h66, 4'h2, 64'h77);
        #1;
`ifdef DECODE_BYPASS_EN
        exp_v = 64'h77;
`else
        exp_v = 64'h55;
`endif
        tests_run++; if (d_valA !== exp_v) begin tests_failed++; $display("FAIL same_cycle_em: got %h expected %h", d_valA, exp_v); end
        step();
        tests_run++; if (d_valA !== 64'h77) begin tests_failed++; $display("FAIL next_cycle_em: got %h expected 77", d_valA); end
        @(negedge clk);
        drive_wb(4'hF, 64'h0, 4'hF, 64'h0);
        stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_fetch(4'h6, 4'h3, 4'h5, 64'h0, 64'h0, 1'b1);
        step();
        @(negedge clk);
        stall = 1'b1;
        drive_wb(4'h5, 64'h99, 4'h3, 64'h98);
        #2;
        rst = 1'b1;
        #1;
        chk4("async_rst_icode", d_icode, 4'h1);
        chk4("async_rst_srcA", d_srcA, 4'hF);
        step();
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        drive_wb(4'hF, 64'h0, 4'hF, 64'h0);
        drive_fetch(4'h6, 4'h3, 4'h5, 64'h0, 64'h0, 1'b1);
        step();
        chk4("after_rst_srcA", d_srcA, 4'h3);
        tests_run++; if (d_valA !== 64'h0) begin tests_failed++; $display("FAIL after_rst_reg3: got %h expected 0", d_valA); end
        tests_run++; if (d_valB !== 64'h0) begin tests_failed++; $display("FAIL after_rst_reg5: got %h expected 0", d_valB); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_popq_collision();
        test_call_jxx();
        test_full_width();
        test_mrmovq_invalid();
        test_stall_bubble();
        test_same_cycle_write();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL expose port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL expose port: rst  input  1  asynchronous reset, active-high.
REQ-003 SHALL expose inputs from fetch: f_icode 4, f_ifun 4, f_rA 4, f_rB 4, f_valC 64, f_valP 64, f_valid 1 (fetch word meaningful).
REQ-004 SHALL expose control inputs: stall 1 (hold D register), bubble 1 (load NOP into D register).
REQ-005 SHALL expose write-back inputs: w_dstE 4, w_valE 64, w_dstM 4, w_valM 64; destination 4'hF = no write.
REQ-006 SHALL expose outputs: d_icode 4, d_ifun 4, d_valC 64, d_valP 64, d_valid 1 (registered copies of fetch fields).
REQ-007 SHALL expose outputs: d_srcA 4, d_srcB 4, d_dstE 4, d_dstM 4, d_valA 64, d_valB 64 (combinational from D register and register file).

Function
REQ-008 SHALL hold 15 x 64-bit registers, IDs 0..14; ID 15 (RNONE) reads 0 and is never written.
REQ-009 D register at rising edge: bubble=1 -> icode=NOP(1), ifun=0, rA=rB=F, valC=valP=0, valid=0; else stall=1 -> hold; else load f_* fields.
REQ-010 stall and bubble both 1 SHALL resolve as bubble.
REQ-011 Latency SHALL be one cycle: fields presented at edge N appear on d_* after edge N; decode outputs settle combinationally in the same cycle.
REQ-012 d_srcA: rA for rrmovq/cmov(2), rmmovq(4), OPq(6), pushq(A); RSP(4) for popq(B), ret(9); else F.
REQ-013 d_srcB: rB for rmmovq(4), mrmovq(5), OPq(6); RSP for pushq, popq, call(8), ret; else F.
REQ-014 d_dstE: rB for rrmovq/cmov, irmovq(3), OPq; RSP for pushq, popq, call, ret; else F (cmov condition is resolved in execute).
REQ-015 d_dstM: rA for mrmovq, popq; else F.
REQ-016 d_valA SHALL be d_valP for call and jXX(7); else value of d_srcA.
REQ-017 d_valB SHALL be value of d_srcB.
REQ-018 When d_valid=0 all of d_srcA/srcB/dstE/dstM SHALL be F and d_valA/d_valB 0.
REQ-019 Invalid icode (C..F) SHALL decode as src/dst all F, no fault raised here.
REQ-020 Write-back at rising edge: w_valE -> reg[w_dstE], then w_valM -> reg[w_dstM]; equal IDs -> w_valM wins.
REQ-021 Register arithmetic: none; all values passed full 64-bit, no truncation.

Reset
REQ-022 rst=1 SHALL asynchronously clear all 15 registers to 0 and load the D register with the bubble value of REQ-009.
REQ-023 rst asserted mid-stall or mid-write SHALL override both; no write-back occurs on an edge where rst is high.
REQ-024 After rst deasserts, first load follows REQ-009 at the next rising edge.

Configuration
REQ-025 Macro DECODE_BYPASS_EN defined: a read whose source ID equals w_dstM returns w_valM, else equals w_dstE returns w_valE, else register file (same-cycle write visible).
REQ-026 Macro DECODE_BYPASS_EN undefined: reads return register file contents only; same-cycle write visible next cycle.

Structure
REQ-027 Shared package y86_pkg SHALL hold icode constants (HALT..POPQ), RNONE=4'hF, RRSP=4'h4, word width 64.
REQ-028 Register file SHALL be a sub-module y86_regfile (two combinational read ports, two write ports, async reset); pipeline register and decode logic in decode_stage.

Verification
REQ-029 Reset: rst pulse -> d_icode=1, d_valid=0, all four IDs F; read of reg 3 after reset = 0.
REQ-030 Write then read: w_dstE=3, w_valE=0xAA; next cycle load OPq rA=3 rB=5 -> d_srcA=3, d_valA=0xAA, d_dstE=5.
REQ-031 popq rA=4: w_dstE=4 w_valE=0x10, w_dstM=4 w_valM=0x20 same edge -> reg 4 = 0x20; load popq rA=6 -> d_srcA=4, d_dstE=4, d_dstM=6.
REQ-032 call valP=0x109 -> d_valA=0x109, d_srcB=4, d_dstE=4, d_srcA=F.
REQ-033 stall=1 two cycles with changing f_* -> d_* unchanged; stall=1,bubble=1 -> NOP, d_valid=0.
REQ-034 With DECODE_BYPASS_EN: D holds rrmovq rA=2 and w_dstM=2 w_valM=0x55 same cycle -> d_valA=0x55; without macro -> old reg 2 value.
